ba_feeder: RTL

//  Sequencer in front of the EPU FP32 bias adder (adder_ba). It accepts accumulator partial sums
//  (psums) on a valid/ready stream and looks up each psum's per-column FP32 bias in a local table.
//  It drives the adder's a/b strobe/ack ports and collects output_z onto a valid/ready result

---
 rtl/ba_feeder.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/ba_feeder.sv
// ba_feeder: sequences psum + per-column bias operations through the external FP32 adder_ba.
// Optional macro BA_RELU_EN clamps negative, non-NaN adder results to +0 at capture.
module ba_feeder #(
  parameter int COLS  = 16,
  parameter int IDX_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bias_we,
  input  logic [IDX_W-1:0] bias_waddr,
  input  logic [31:0]      bias_wdata,
  input  logic             psum_valid,
  output logic             psum_ready,
  input  logic [31:0]      psum_data,
  input  logic [IDX_W-1:0] psum_col,
  input  logic             psum_last,
  output logic [31:0]      add_a,
  output logic             add_a_stb,
  input  logic             add_a_ack,
  output logic [31:0]      add_b,
  output logic             add_b_stb,
  input  logic             add_b_ack,
  input  logic [31:0]      add_z,
  input  logic             add_z_stb,
  output logic             add_z_ack,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data,
  output logic             res_last,
  output logic [CNT_W-1:0] done_cnt
);

  typedef enum logic [2:0] {IDLE, SEND_A, SEND_B, WAIT_Z, OUT} state_t;

  localparam logic [IDX_W:0] COLS_LIM = (IDX_W + 1)'(COLS);

  state_t             state_q;
  logic               psum_ready_q;
  logic [31:0]        add_a_q;
  logic [31:0]        add_b_q;
  logic               add_a_stb_q;
  logic               add_b_stb_q;
  logic               add_z_ack_q;
  logic               res_valid_q;
  logic [31:0]        res_data_q;
  logic               res_last_q;
  logic               last_q;
  logic [CNT_W-1:0]   done_cnt_q;
  logic [31:0]        bias_q [COLS];
  logic [31:0]        bias_rd_d;
  logic [31:0]        res_z_d;

  // Columns beyond the table read as zero bias.
  always_comb begin
    bias_rd_d = '0;
    if ({1'b0, psum_col} < COLS_LIM) begin
      bias_rd_d = bias_q[psum_col];
    end
  end

  always_comb begin
    res_z_d = add_z;
`ifdef BA_RELU_EN
    if (add_z[31] && ((add_z[30:23] != 8'hFF) || (add_z[22:0] == 23'd0))) begin
      res_z_d = 32'h0000_0000;
    end
`endif
  end

  // The table read above sees the pre-write value, so a same-cycle write is stored but not used.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < COLS; i++) begin
        bias_q[i] <= '0;
      end
    end else if (bias_we && ({1'b0, bias_waddr} < COLS_LIM)) begin
      bias_q[bias_waddr] <= bias_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      psum_ready_q <= 1'b0;
      add_a_q      <= '0;
      add_b_q      <= '0;
      add_a_stb_q  <= 1'b0;
      add_b_stb_q  <= 1'b0;
      add_z_ack_q  <= 1'b0;
      res_valid_q  <= 1'b0;
      res_data_q   <= '0;
      res_last_q   <= 1'b0;
      last_q       <= 1'b0;
      done_cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (psum_valid && psum_ready_q) begin
            add_a_q      <= psum_data;
            add_b_q      <= bias_rd_d;
            last_q       <= psum_last;
            psum_ready_q <= 1'b0;
            add_a_stb_q  <= 1'b1;
            state_q      <= SEND_A;
          end else begin
            psum_ready_q <= 1'b1;
          end
        end
        SEND_A: begin
          if (add_a_ack) begin
            add_a_stb_q <= 1'b0;
            add_b_stb_q <= 1'b1;
            state_q     <= SEND_B;
          end
        end
        SEND_B: begin
          if (add_b_ack) begin
            add_b_stb_q <= 1'b0;
            add_z_ack_q <= 1'b1;
            state_q     <= WAIT_Z;
          end
        end
        WAIT_Z: begin
          if (add_z_stb) begin
            res_data_q  <= res_z_d;
            res_last_q  <= last_q;
            res_valid_q <= 1'b1;
            add_z_ack_q <= 1'b0;
            state_q     <= OUT;
          end
        end
        OUT: begin
          if (res_ready) begin
            res_valid_q  <= 1'b0;
            done_cnt_q   <= done_cnt_q + CNT_W'(1);
            psum_ready_q <= 1'b1;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign psum_ready = psum_ready_q;
  assign add_a      = add_a_q;
  assign add_b      = add_b_q;
  assign add_a_stb  = add_a_stb_q;
  assign add_b_stb  = add_b_stb_q;
  assign add_z_ack  = add_z_ack_q;
  assign res_valid  = res_valid_q;
  assign res_data   = res_data_q;
  assign res_last   = res_last_q;
  assign done_cnt   = done_cnt_q;

endmodule
